// File: rtl/sin_lut_pkg.sv
// Shared constants and helpers for the shared quarter-wave sine lookup.
package sin_lut_pkg;

  localparam int unsigned PHASE_W_DEF = 12;
  localparam int unsigned OUT_W_DEF   = 16;

  localparam real PI = 3.14159265358979323846;

  // Quadrant is the top two phase bits.
  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quadrant_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

  // First-quadrant entry k. The half-code offset keeps the table symmetric under mirroring,
  // and the peak stays at 2^(out_w-1)-1 so negation cannot overflow.
  function automatic int rom_value(input int k, input int phase_w, input int out_w);
    real amp;
    real ang;
    amp = real'((longint'(1) << (out_w - 1)) - 1);
    ang = 2.0 * PI * (real'(k) + 0.5) / real'(longint'(1) << phase_w);
    return $rtoi(amp * $sin(ang) + 0.5);
  endfunction

endpackage

// File: rtl/sin_qrom.sv
// Quarter-wave sine ROM with one registered read port.
module sin_qrom
  import sin_lut_pkg::*;
#(
  parameter int unsigned PHASE_W = PHASE_W_DEF,
  parameter int unsigned OUT_W   = OUT_W_DEF,
  parameter int unsigned ADDR_W  = PHASE_W - 2
) (
  input  logic                     clk,
  input  logic [ADDR_W-1:0]        addr,
  output logic signed [OUT_W-1:0]  data
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic signed [OUT_W-1:0] rom [DEPTH];

  // Table contents are elaboration-time constants.
  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    assign rom[k] = OUT_W'(rom_value(k, PHASE_W, OUT_W));
  end

  // Registered read, data path deliberately unreset.
  always_ff @(posedge clk) begin
    data <= rom[addr];
  end

endmodule

// File: rtl/sin_lut_arbiter.sv
// Round-robin front end sharing one quarter-wave sine ROM between N_REQ requesters.
// Three stages: capture/fold, ROM read, sign restore.
module sin_lut_arbiter
  import sin_lut_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned PHASE_W = PHASE_W_DEF,
  parameter int unsigned OUT_W   = OUT_W_DEF,
  localparam int unsigned ADDR_W = PHASE_W - 2,
  localparam int unsigned ID_W   = clog2(N_REQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*PHASE_W-1:0]   phase,
  output logic [N_REQ-1:0]           gnt,
  output logic                       rsp_valid,
  output logic [ID_W-1:0]            rsp_id,
  output logic signed [OUT_W-1:0]    rsp_data
);

  logic [ID_W-1:0]          rr;
  logic [ID_W-1:0]          gnt_idx;
  logic [ID_W-1:0]          cand;
  logic                     found;
  logic [PHASE_W-1:0]       sel_phase;

  logic                     s1_valid;
  logic [ID_W-1:0]          s1_id;
  quadrant_e                s1_q;
  logic [ADDR_W-1:0]        s1_idx;
  logic [ADDR_W-1:0]        rom_addr;

  logic                     s2_valid;
  logic [ID_W-1:0]          s2_id;
  quadrant_e                s2_q;
  logic signed [OUT_W-1:0]  rom_data;

  // Grant the first requester at or above rr, wrapping around.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    cand    = '0;
    found   = 1'b0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      cand = ID_W'((32'(rr) + off) % N_REQ);
      if (!found && req[cand]) begin
        found        = 1'b1;
        gnt[cand]    = 1'b1;
        gnt_idx      = cand;
      end
    end
  end

  // Mux the granted requester's phase word.
  always_comb begin
    sel_phase = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt[i]) sel_phase = phase[i*PHASE_W +: PHASE_W];
    end
  end

  // Pointer advances past the winner only on a transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr <= '0;
    end else if (|req) begin
      rr <= (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // S1: capture id, quadrant and in-quadrant index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_id    <= '0;
      s1_q     <= Q0;
      s1_idx   <= '0;
    end else begin
      s1_valid <= |req;
      if (|req) begin
        s1_id  <= gnt_idx;
        s1_q   <= quadrant_e'(sel_phase[PHASE_W-1 -: 2]);
        s1_idx <= sel_phase[ADDR_W-1:0];
      end
    end
  end

  // Odd quadrants run the table backwards.
  always_comb begin
    rom_addr = (s1_q == Q1 || s1_q == Q3) ? ~s1_idx : s1_idx;
  end

  sin_qrom #(
    .PHASE_W (PHASE_W),
    .OUT_W   (OUT_W),
    .ADDR_W  (ADDR_W)
  ) u_rom (
    .clk  (clk),
    .addr (rom_addr),
    .data (rom_data)
  );

  // S2: carry id and quadrant alongside the ROM read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid <= 1'b0;
      s2_id    <= '0;
      s2_q     <= Q0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_id <= s1_id;
        s2_q  <= s1_q;
      end
    end
  end

  // S3: restore sign for the lower half-period; outputs hold while idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= s2_valid;
      if (s2_valid) begin
        rsp_id   <= s2_id;
        rsp_data <= (s2_q == Q0 || s2_q == Q1) ? rom_data : -rom_data;
      end
    end
  end

endmodule

// File: tb/tb_sin_lut_arbiter.sv
// Scoreboard bench: grants checked against a round-robin model each cycle, results against
// a full-period rounded sine computed directly from the phase.
module tb_sin_lut_arbiter;

  localparam int N  = 4;
  localparam int PW = 12;
  localparam int OW = 16;
  localparam real PI = 3.14159265358979323846;

  logic                   clk;
  logic                   rst;
  logic [N-1:0]           req;
  logic [N*PW-1:0]        phase;
  logic [N-1:0]           gnt;
  logic                   rsp_valid;
  logic [1:0]             rsp_id;
  logic signed [OW-1:0]   rsp_data;

  typedef struct {
    int id;
    int ph;
    int data;
    int due;
  } exp_t;

  exp_t sb[$];
  int   n_tests;
  int   n_fail;
  int   cyc;
  int   model_rr;
  int   got [4096];

  sin_lut_arbiter #(
    .N_REQ   (N),
    .PHASE_W (PW),
    .OUT_W   (OW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .phase     (phase),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int golden(input int p);
    real v;
    v = 32767.0 * $sin(2.0 * PI * (real'(p) + 0.5) / 4096.0);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
  endfunction

  function automatic logic [N-1:0] model_gnt(input logic [N-1:0] r, input int rr);
    for (int off = 0; off < N; off++) begin
      if (r[(rr + off) % N]) return N'(1) << ((rr + off) % N);
    end
    return '0;
  endfunction

  function automatic logic [N*PW-1:0] mk_ph(input int i, input int p);
    logic [N*PW-1:0] v;
    v = '0;
    v[i*PW +: PW] = PW'(p);
    return v;
  endfunction

  // Output monitor: pops the scoreboard on every result, flags missing or stray ones.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL stray_rsp: rsp_valid=1 id=%0d data=%0d, required no result", rsp_id,
                   rsp_data);
        end else begin
          e = sb.pop_front();
          n_tests += 3;
          if (int'(rsp_id) !== e.id) begin
            n_fail++;
            $display("FAIL rsp_id: got %0d want %0d (phase %0d)", rsp_id, e.id, e.ph);
          end
          if (int'(rsp_data) !== e.data) begin
            n_fail++;
            $display("FAIL rsp_data: got %0d want %0d (phase %0d)", rsp_data, e.data, e.ph);
          end
          if (cyc !== e.due) begin
            n_fail++;
            $display("FAIL latency: result at cycle %0d want %0d", cyc, e.due);
          end
          got[e.ph] = int'(rsp_data);
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        n_tests++;
        n_fail++;
        $display("FAIL missing_rsp: rsp_valid=0 at cycle %0d want id %0d phase %0d", cyc,
                 e.id, e.ph);
      end
    end
  end

  // One cycle of stimulus; checks the combinational grant and books the expected result.
  task automatic drive(input logic [N-1:0] r, input logic [N*PW-1:0] ph);
    logic [N-1:0] eg;
    exp_t e;
    @(negedge clk);
    req   = r;
    phase = ph;
    #1;
    eg = model_gnt(r, model_rr);
    n_tests++;
    if (gnt !== eg) begin
      n_fail++;
      $display("FAIL gnt: got %b want %b (req %b)", gnt, eg, r);
    end
    for (int i = 0; i < N; i++) begin
      if (eg[i]) begin
        e.id   = i;
        e.ph   = int'(ph[i*PW +: PW]);
        e.data = golden(e.ph);
        e.due  = cyc + 3;
        sb.push_back(e);
        model_rr = (i + 1) % N;
      end
    end
  endtask

  task automatic drain();
    int budget;
    budget = 20;
    while (sb.size() > 0 && budget > 0) begin
      drive('0, '0);
      budget--;
    end
    drive('0, '0);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding, want 0", sb.size());
    end
  endtask

  task automatic test_reset();
    rst   = 1'b0;
    req   = '0;
    phase = '0;
    #1;
    n_tests += 4;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", rsp_valid); end
    if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL reset_id: got %0d want 0", rsp_id); end
    if (rsp_data !== 16'sd0) begin n_fail++; $display("FAIL reset_data: got %0d want 0", rsp_data); end
    if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_rr = 0;
  endtask

  task automatic test_single();
    drive(4'b0001, mk_ph(0, 0));
    n_tests++;
    if (gnt !== 4'b0001) begin n_fail++; $display("FAIL single_gnt: got %b want 0001", gnt); end
    drain();
    n_tests++;
    if (got[0] !== 25) begin n_fail++; $display("FAIL single_data: got %0d want 25", got[0]); end
  endtask

  task automatic test_rotation_wrap();
    drive(4'b1000, mk_ph(3, 100));
    drive(4'b1001, mk_ph(0, 200) | mk_ph(3, 300));
    n_tests++;
    if (gnt !== 4'b0001) begin n_fail++; $display("FAIL wrap_first: got %b want 0001", gnt); end
    drive(4'b1000, mk_ph(3, 300));
    n_tests++;
    if (gnt !== 4'b1000) begin n_fail++; $display("FAIL wrap_second: got %b want 1000", gnt); end
    drain();
  endtask

  task automatic test_all_req();
    logic [N*PW-1:0] ph;
    for (int k = 0; k < 8; k++) begin
      ph = '0;
      for (int i = 0; i < N; i++) ph[i*PW +: PW] = PW'(i * 700 + k * 13);
      drive(4'b1111, ph);
      n_tests++;
      if (gnt !== (4'b0001 << (k % 4))) begin
        n_fail++;
        $display("FAIL all_req_order: cycle %0d got %b want %b", k, gnt, 4'b0001 << (k % 4));
      end
    end
    drain();
  endtask

  task automatic test_back_to_back();
    drive(4'b0010, mk_ph(1, 1024));
    drive(4'b0010, mk_ph(1, 2048));
    drive(4'b0010, mk_ph(1, 3072));
    drain();
    n_tests += 3;
    if (got[1024] !== 32767) begin n_fail++; $display("FAIL b2b_1024: got %0d want 32767", got[1024]); end
    if (got[2048] !== -25) begin n_fail++; $display("FAIL b2b_2048: got %0d want -25", got[2048]); end
    if (got[3072] !== -32767) begin n_fail++; $display("FAIL b2b_3072: got %0d want -32767", got[3072]); end
  endtask

  task automatic test_sweep();
    for (int p = 0; p < 4096; p++) drive(4'b0100, mk_ph(2, p));
    drain();
    for (int p = 0; p < 2048; p++) begin
      n_tests++;
      if (got[p + 2048] !== -got[p]) begin
        n_fail++;
        $display("FAIL symmetry: sample(%0d)=%0d want %0d", p + 2048, got[p + 2048], -got[p]);
      end
    end
  endtask

  task automatic test_reset_in_flight();
    drive(4'b0001, mk_ph(0, 500));
    drive(4'b0001, mk_ph(0, 600));
    drive('0, '0);
    @(posedge clk);
    #1;
    n_tests++;
    if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_valid: got %b want 1", rsp_valid); end
    rst = 1'b0;
    #1;
    sb.delete();
    model_rr = 0;
    n_tests++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL async_reset_valid: got %b want 0", rsp_valid); end
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    drive(4'b1010, mk_ph(1, 700) | mk_ph(3, 800));
    n_tests++;
    if (gnt !== 4'b0010) begin n_fail++; $display("FAIL post_reset_gnt: got %b want 0010", gnt); end
    drive(4'b1000, mk_ph(3, 800));
    drain();
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    cyc      = 0;
    model_rr = 0;
    for (int p = 0; p < 4096; p++) got[p] = 99999;
    test_reset();
    test_single();
    test_rotation_wrap();
    test_all_req();
    test_back_to_back();
    test_sweep();
    test_reset_in_flight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sin_lut_arbiter.md
Name: sin_lut_arbiter

Overview:
Shares one quarter-wave sine ROM between N_REQ requesters, such as per-channel phase accumulators.
- Round-robin arbiter accepts at most one phase lookup per clock.
- Three-stage pipeline performs quadrant folding, ROM read and sign restore.
- Each result returns tagged with the requester ID.
- Sits between the channel phase generators and the DSP consumers; replaces one full-table LUT per channel.

Parameters:
N_REQ, 4, number of requesters (2..16)
PHASE_W, 12, phase word width; one full sine period = 2^PHASE_W codes
OUT_W, 16, signed sample width
(derived localparams: ADDR_W = PHASE_W-2, ID_W = clog2(N_REQ))

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
req  in  N_REQ  per-requester lookup request, level
phase  in  N_REQ*PHASE_W  packed phases; requester i uses bits [i*PHASE_W +: PHASE_W]
gnt  out  N_REQ  one-hot grant, combinational from req and rr pointer
rsp_valid  out  1  result valid for one cycle
rsp_id  out  ID_W  requester index of result
rsp_data  out  OUT_W  signed sine sample

Behaviour:
- Reset (rst low, async):
  - rr pointer = 0; all pipeline valid bits = 0.
  - rsp_valid = 0, rsp_id = 0, rsp_data = 0.
  - In-flight lookups are dropped, never replayed.
- Handshake:
  - Transfer on a rising edge where req[i] & gnt[i].
  - Requester holds req and phase stable until it sees gnt.
  - Requester may keep req high for back-to-back transfers.
- Arbitration:
  - gnt = first set req bit searching from index rr upward, wrapping.
  - At most one gnt bit set; gnt = 0 when req = 0.
  - On transfer to i, rr <= (i+1) mod N_REQ. rr is unchanged when idle.
  - A continuously requesting port waits at most N_REQ-1 cycles.
- Pipeline (throughput 1/clk, no backpressure; consumer must accept every rsp_valid):
  - S1, accept edge n: capture id, quadrant q = phase[PW-1:PW-2], idx = phase[PW-3:0].
  - S2, edge n+1:
    - addr = idx when q is 0 or 2; addr = ~idx when q is 1 or 3.
    - ROM registered read; q and id carried alongside.
  - S3, edge n+2:
    - rsp_data = ROM when q < 2; rsp_data = -ROM otherwise.
    - rsp_valid = 1; rsp_id = id.
  - Latency: result valid in the cycle after edge n+2.
  - rsp_data and rsp_id hold their last value while rsp_valid = 0.
- ROM contents:
  - ROM[k] = round((2^(OUT_W-1)-1) * sin(2*pi*(k+0.5)/2^PHASE_W)), k = 0..2^ADDR_W-1.
  - The half-code offset makes mirroring exact; |value| <= 2^(OUT_W-1)-1, so negation never overflows.
- Boundaries:
  - Phase wrap 2^PW-1 -> 0 needs no special case.
  - Simultaneous req from all ports: strict rotation.
  - req asserted the same cycle rst releases: not granted until the first edge after release.

Decomposition:
- Package sin_lut_pkg holds:
  - PHASE_W / OUT_W defaults;
  - quadrant encoding constants (Q0..Q3);
  - the ROM init function computing ROM[k];
  - the clog2 helper.
- Sub-module sin_qrom: synchronous-read quarter-wave ROM with ports clk, addr, data. One registered output, no reset on the data path.
- Arbiter and pipeline live in the top module.

Test Plan:
- Reset then single req[0], phase 0 -> gnt[0] same cycle; rsp_valid 3 cycles later; rsp_id 0; rsp_data 25 (PW=12, OW=16).
- req[1] phases 1024, 2048, 3072 back-to-back -> consecutive rsp_data 32767, -25, -32767; rsp_id 1 each.
- All four req held high for 8 cycles -> gnt order 0,1,2,3,0,1,2,3; rsp_id follows the same order; no gaps in rsp_valid.
- Sweep req[2] phase 0..4095 -> every result matches the golden rounded sine within 0 LSB; sample(p+2048) = -sample(p) for all p.
- Assert rst low with 2 lookups in flight -> rsp_valid 0 immediately; no stale result after release; first post-reset grant goes to the lowest-indexed requester.
- req[3] only, then req[0]+req[3] together -> rr after port 3 wraps to 0; gnt[0] wins, then gnt[3].
